// File: rtl/mult_host_seq.sv
// Host-side sequencer for a memory-mapped multiplier peripheral: writes both operands,
// starts the unit, polls status, then reads back the result and count words.
module mult_host_seq #(
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned POLL_MAX   = 255,
  parameter logic [15:0] ADDR_A1    = 16'h037F,
  parameter logic [15:0] ADDR_A2    = 16'h0388,
  parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
  parameter logic [15:0] ADDR_W     = 16'h0390,
  parameter logic [15:0] ADDR_L     = 16'h0398
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_w,
  output logic [23:0] rsp_l,
  output logic        rsp_timeout,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_in,
  input  logic [31:0] sdata_out
);

  typedef enum logic [3:0] {
    IDLE, WR_A1, WR_A2, WR_GO, RD_STAT, RD_W0, RD_W1, RD_L, RESP
  } state_t;

  // Access phases: 0 = setup, 1..STROBE_LEN = strobe, STROBE_LEN+1 = hold.
  localparam logic [4:0]  STB_LAST = 5'(STROBE_LEN);
  localparam logic [4:0]  HOLD_PH  = 5'(STROBE_LEN + 1);
  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  state_t      state;
  logic [4:0]  phase;
  logic        poll_gap;
  logic [15:0] poll_cnt;
  logic [23:0] a2_q;
  logic [31:0] w_q;

  function automatic logic is_read(input state_t s);
    return (s == RD_STAT) || (s == RD_W0) || (s == RD_W1) || (s == RD_L);
  endfunction

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      phase       <= '0;
      poll_gap    <= 1'b0;
      poll_cnt    <= '0;
      a2_q        <= '0;
      w_q         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_w       <= '0;
      rsp_l       <= '0;
      rsp_timeout <= 1'b0;
      saddress    <= '0;
      sdata_in    <= '0;
      srd         <= 1'b0;
      swr         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // a1 goes straight onto the bus; a2 is kept for the second write.
            a2_q        <= cmd_a2;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b0;
            state       <= WR_A1;
            phase       <= '0;
            saddress    <= ADDR_A1;
            sdata_in    <= {8'h0, cmd_a1};
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          if (state == RD_STAT && poll_gap) begin
            // Idle cycle between status polls is over: set up the next read.
            poll_gap <= 1'b0;
            phase    <= '0;
            saddress <= ADDR_CTRL;
            sdata_in <= '0;
          end else if (phase != HOLD_PH) begin
            phase <= phase + 5'd1;
            srd   <= (phase < STB_LAST) && is_read(state);
            swr   <= (phase < STB_LAST) && !is_read(state);
          end else begin
            // Hold cycle: read data is sampled here and the next access is set up.
            phase    <= '0;
            saddress <= '0;
            sdata_in <= '0;
            case (state)
              WR_A1: begin
                state    <= WR_A2;
                saddress <= ADDR_A2;
                sdata_in <= {8'h0, a2_q};
              end
              WR_A2: begin
                state    <= WR_GO;
                saddress <= ADDR_CTRL;
                poll_cnt <= '0;
              end
              WR_GO: begin
                state    <= RD_STAT;
                saddress <= ADDR_CTRL;
              end
              RD_STAT: begin
                if (sdata_out[1:0] != 2'b11) begin
                  state    <= RD_W0;
                  saddress <= ADDR_W;
                end else if (poll_cnt < POLL_LIM) begin
                  poll_cnt <= poll_cnt + 16'd1;
                  poll_gap <= 1'b1;
                end else begin
                  state       <= RESP;
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_w       <= '0;
                  rsp_l       <= '0;
                end
              end
              RD_W0: begin
                // First W read returns the previously latched word; discard it.
                state    <= RD_W1;
                saddress <= ADDR_W;
              end
              RD_W1: begin
                state    <= RD_L;
                w_q      <= sdata_out;
                saddress <= ADDR_L;
              end
              RD_L: begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_w     <= w_q;
                rsp_l     <= sdata_out[23:0];
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_host_seq.sv
// Randomized bench for mult_host_seq: three instances (STROBE_LEN 2, 1, 4) against a
// behavioural peripheral, with bus traces and responses compared to an abstract model.
module tb_mult_host_seq;

  localparam int          POLL_MAX_T = 4;
  localparam logic [15:0] A_A1   = 16'h037F;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] rise;
    logic [7:0]  slen;
  } acc_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        cmd_valid [3];
  logic        cmd_ready [3];
  logic [23:0] cmd_a1 [3];
  logic [23:0] cmd_a2 [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_w [3];
  logic [23:0] rsp_l [3];
  logic        rsp_timeout [3];
  logic [15:0] saddress [3];
  logic        srd [3];
  logic        swr [3];
  logic [31:0] sdata_in [3];
  logic [31:0] sdata_out [3];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // Peripheral model state and per-command configuration
  int          cfg_busy [3];
  logic [31:0] cfg_w [3];
  logic [23:0] cfg_l [3];
  logic [1:0]  cfg_done [3];
  int          stat_left [3];
  logic [1:0]  done_code [3];
  logic [31:0] w_next [3];
  logic [31:0] w_shown [3];
  logic [23:0] l_val [3];
  logic        pend [3];
  logic        pend_rd [3];
  logic [15:0] pend_addr [3];

  // Bus monitor state
  int          run [3];
  logic        prev_stb [3];
  logic [15:0] prev_addr [3];
  logic [31:0] prev_data [3];
  logic        cur_rd [3];
  logic [15:0] cur_addr [3];
  logic [31:0] cur_data [3];
  int          cur_rise [3];
  acc_t        acc_q [3][$];
  acc_t        mon_a;

  logic [31:0] last_w [3];
  logic [23:0] last_l [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mult_host_seq #(
      .STROBE_LEN(g == 0 ? 2 : (g == 1 ? 1 : 4)),
      .POLL_MAX  (POLL_MAX_T)
    ) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_a1     (cmd_a1[g]),
      .cmd_a2     (cmd_a2[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_w      (rsp_w[g]),
      .rsp_l      (rsp_l[g]),
      .rsp_timeout(rsp_timeout[g]),
      .saddress   (saddress[g]),
      .srd        (srd[g]),
      .swr        (swr[g]),
      .sdata_in   (sdata_in[g]),
      .sdata_out  (sdata_out[g])
    );
  end

  function automatic int sl(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Peripheral read data: status busy while stat_left > 0, W returns the older latched word.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sdata_out[i] = 32'h0;
      if (saddress[i] == A_CTRL)
        sdata_out[i] = (stat_left[i] > 0) ? 32'hABCD_1237 : {30'h2D2D_2D2D, done_code[i]};
      else if (saddress[i] == A_W)
        sdata_out[i] = w_shown[i];
      else if (saddress[i] == A_L)
        sdata_out[i] = {8'hA5, l_val[i]};
    end
  end

  // Bus monitor and peripheral side effects (applied the cycle after each hold).
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        pend[i] = 1'b0;
        if (!pend_rd[i] && pend_addr[i] == A_CTRL) begin
          stat_left[i] = cfg_busy[i];
          w_next[i]    = cfg_w[i];
          l_val[i]     = cfg_l[i];
          done_code[i] = cfg_done[i];
        end
        if (pend_rd[i] && pend_addr[i] == A_CTRL && stat_left[i] > 0) stat_left[i]--;
        if (pend_rd[i] && pend_addr[i] == A_W) w_shown[i] = w_next[i];
      end
      if (!n_reset) begin
        run[i] = 0;
      end else if (srd[i] || swr[i]) begin
        chk("strobe_excl", 32'(srd[i] & swr[i]), 32'd0);
        if (run[i] == 0) begin
          chk("setup_stb", 32'(prev_stb[i]), 32'd0);
          chk("setup_addr", 32'(prev_addr[i]), 32'(saddress[i]));
          chk("setup_data", prev_data[i], sdata_in[i]);
          cur_rd[i]   = srd[i];
          cur_addr[i] = saddress[i];
          cur_data[i] = sdata_in[i];
          cur_rise[i] = cyc;
        end else begin
          chk("stb_addr", 32'(saddress[i]), 32'(cur_addr[i]));
          chk("stb_data", sdata_in[i], cur_data[i]);
          chk("stb_kind", 32'(srd[i]), 32'(cur_rd[i]));
        end
        run[i]++;
      end else if (run[i] > 0) begin
        chk("hold_addr", 32'(saddress[i]), 32'(cur_addr[i]));
        chk("hold_data", sdata_in[i], cur_data[i]);
        mon_a.rd   = cur_rd[i];
        mon_a.addr = cur_addr[i];
        mon_a.data = cur_rd[i] ? sdata_out[i] : cur_data[i];
        mon_a.rise = 32'(cur_rise[i]);
        mon_a.slen = 8'(run[i]);
        acc_q[i].push_back(mon_a);
        pend[i]      = 1'b1;
        pend_rd[i]   = cur_rd[i];
        pend_addr[i] = cur_addr[i];
        run[i]       = 0;
      end
      prev_stb[i]  = srd[i] | swr[i];
      prev_addr[i] = saddress[i];
      prev_data[i] = sdata_in[i];
    end
  end

  task automatic chk_reset_outputs(input int i);
    chk("rst_cmd_ready", 32'(cmd_ready[i]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    chk("rst_rsp_w", rsp_w[i], 32'd0);
    chk("rst_rsp_l", 32'(rsp_l[i]), 32'd0);
    chk("rst_rsp_tmo", 32'(rsp_timeout[i]), 32'd0);
    chk("rst_saddress", 32'(saddress[i]), 32'd0);
    chk("rst_srd", 32'(srd[i]), 32'd0);
    chk("rst_swr", 32'(swr[i]), 32'd0);
    chk("rst_sdata_in", sdata_in[i], 32'd0);
  endtask

  // One full command on instance i, with rsp_ready held low for 'hold' cycles of RESP.
  task automatic run_cmd(input int i, input logic [23:0] a1, input logic [23:0] a2,
                         input int busy, input logic [31:0] w, input logic [23:0] l,
                         input int hold);
    int t;
    int k;
    int nstat;
    int lag;
    bit tmo;
    logic [31:0] ew;
    logic [23:0] el;
    logic        er [$];
    logic [15:0] ea [$];
    logic [31:0] ed [$];
    cfg_busy[i] = busy;
    cfg_w[i]    = w;
    cfg_l[i]    = l;
    cfg_done[i] = 2'($urandom_range(0, 2));
    acc_q[i].delete();
    t = 0;
    while (!cmd_ready[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready[i]), 32'd1);
    cmd_valid[i] = 1'b1;
    cmd_a1[i]    = a1;
    cmd_a2[i]    = a2;
    k = cyc;
    @(negedge clk);
    chk("acc_ready_low", 32'(cmd_ready[i]), 32'd0);
    chk("acc_tmo_clear", 32'(rsp_timeout[i]), 32'd0);
    chk("acc_w_held", rsp_w[i], last_w[i]);
    chk("acc_l_held", 32'(rsp_l[i]), 32'(last_l[i]));
    // Keep requesting with junk operands: must be ignored mid-sequence.
    cmd_a1[i] = 24'($urandom);
    cmd_a2[i] = 24'($urandom);
    t = 0;
    while (!rsp_valid[i] && t < 3000) begin
      if (cmd_ready[i]) chk("busy_cmd_ready", 32'(cmd_ready[i]), 32'd0);
      @(negedge clk);
      t++;
    end
    if (!rsp_valid[i]) begin
      chk("rsp_wait_timeout", 32'(rsp_valid[i]), 32'd1);
      cmd_valid[i] = 1'b0;
      return;
    end
    tmo = (busy > POLL_MAX_T);
    ew  = tmo ? 32'h0 : w;
    el  = tmo ? 24'h0 : l;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 32'(rsp_valid[i]), 32'd1);
      chk("resp_w", rsp_w[i], ew);
      chk("resp_l", 32'(rsp_l[i]), 32'(el));
      chk("resp_tmo", 32'(rsp_timeout[i]), 32'(tmo));
      chk("resp_cmd_ready", 32'(cmd_ready[i]), 32'd0);
      chk("resp_bus_idle", {15'h0, srd[i] | swr[i], saddress[i]} | sdata_in[i], 32'd0);
      if (h < hold) begin
        cmd_valid[i] = 1'b1;
        @(negedge clk);
      end
    end
    cmd_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    chk("rel_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    chk("rel_cmd_ready", 32'(cmd_ready[i]), 32'd1);
    chk("rel_w_held", rsp_w[i], ew);
    chk("rel_tmo_held", 32'(rsp_timeout[i]), 32'(tmo));
    last_w[i] = ew;
    last_l[i] = el;
    // Expected bus trace from the protocol rules.
    nstat = tmo ? POLL_MAX_T + 1 : busy + 1;
    er.push_back(1'b0); ea.push_back(A_A1);   ed.push_back({8'h0, a1});
    er.push_back(1'b0); ea.push_back(A_A2);   ed.push_back({8'h0, a2});
    er.push_back(1'b0); ea.push_back(A_CTRL); ed.push_back(32'h0);
    for (int s = 0; s < nstat; s++) begin
      er.push_back(1'b1); ea.push_back(A_CTRL); ed.push_back(32'h0);
    end
    if (!tmo) begin
      er.push_back(1'b1); ea.push_back(A_W); ed.push_back(32'h0);
      er.push_back(1'b1); ea.push_back(A_W); ed.push_back(32'h0);
      er.push_back(1'b1); ea.push_back(A_L); ed.push_back(32'h0);
    end
    chk("trace_len", 32'(acc_q[i].size()), 32'(ea.size()));
    for (int j = 0; j < ea.size() && j < acc_q[i].size(); j++) begin
      chk("trace_rd", 32'(acc_q[i][j].rd), 32'(er[j]));
      chk("trace_addr", 32'(acc_q[i][j].addr), 32'(ea[j]));
      if (!er[j]) chk("trace_wdata", acc_q[i][j].data, ed[j]);
      chk("trace_strobe_len", 32'(acc_q[i][j].slen), 32'(sl(i)));
      if (j == 0) lag = k + 2;
      else if (er[j] && er[j-1] && ea[j] == A_CTRL && ea[j-1] == A_CTRL)
        lag = int'(acc_q[i][j-1].rise) + sl(i) + 3;
      else
        lag = int'(acc_q[i][j-1].rise) + sl(i) + 2;
      chk("trace_spacing", acc_q[i][j].rise, 32'(lag));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 1'b0; cmd_a1[i] = '0; cmd_a2[i] = '0; rsp_ready[i] = 1'b0;
      cfg_busy[i] = 0; cfg_w[i] = '0; cfg_l[i] = '0; cfg_done[i] = 2'b00;
      stat_left[i] = 0; done_code[i] = 2'b00; w_next[i] = 32'hDEAD_BEEF;
      w_shown[i] = 32'hDEAD_BEEF; l_val[i] = '0; pend[i] = 1'b0; pend_rd[i] = 1'b0;
      pend_addr[i] = '0; run[i] = 0; prev_stb[i] = 1'b0; prev_addr[i] = '0;
      prev_data[i] = '0; last_w[i] = '0; last_l[i] = '0;
    end
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_outputs(i);
    n_reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("post_rst_ready", 32'(cmd_ready[i]), 32'd1);

    run_cmd(0, 24'd3, 24'd4, 2, 32'h30, 24'd1, 0);
    run_cmd(0, 24'($urandom), 24'($urandom), 1, $urandom, 24'($urandom), 10);
    run_cmd(0, 24'($urandom), 24'($urandom), 1000, $urandom, 24'($urandom), 1);
    run_cmd(0, 24'($urandom), 24'($urandom), 0, $urandom, 24'($urandom), 0);
    for (int n = 0; n < 6; n++)
      run_cmd(0, 24'($urandom), 24'($urandom), $urandom_range(0, 6), $urandom,
              24'($urandom), $urandom_range(0, 3));
    for (int i = 1; i < 3; i++) begin
      run_cmd(i, 24'($urandom), 24'($urandom), $urandom_range(0, 3), $urandom,
              24'($urandom), 0);
      run_cmd(i, 24'($urandom), 24'($urandom), 1000, $urandom, 24'($urandom), 2);
      run_cmd(i, 24'($urandom), 24'($urandom), $urandom_range(0, 4), $urandom,
              24'($urandom), 1);
    end

    // Reset during the strobe of the A2 write, then a full command from the top.
    acc_q[0].delete();
    cfg_busy[0] = 1;
    cmd_valid[0] = 1'b1;
    cmd_a1[0] = 24'h12_3456;
    cmd_a2[0] = 24'h65_4321;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    t = 0;
    while (!(swr[0] && saddress[0] == A_A2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wr_a2_strobe_seen", 32'(swr[0] && saddress[0] == A_A2), 32'd1);
    n_reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_outputs(i);
    n_reset = 1'b1;
    @(negedge clk);
    chk("post_rst2_ready", 32'(cmd_ready[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      last_w[i] = '0;
      last_l[i] = '0;
    end
    run_cmd(0, 24'($urandom), 24'($urandom), 2, $urandom, 24'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mult_host_seq.md
MULT_HOST_SEQ -- requirements
Module: mult_host_seq

Interface
REQ-001 SHALL have parameter STROBE_LEN, default 2: cycles srd/swr held high per access, legal range 1..15.
REQ-002 SHALL have parameter POLL_MAX, default 255: maximum status reads before timeout, legal range 1..65535.
REQ-003 SHALL have parameters ADDR_A1 16'h037F, ADDR_A2 16'h0388, ADDR_CTRL 16'h03A0, ADDR_W 16'h0390, ADDR_L 16'h0398: peripheral register map.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port n_reset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 SHALL have ports cmd_a1 and cmd_a2  in  24 each  operands.
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  result consumed.
REQ-011 SHALL have ports rsp_w  out  32  result word; rsp_l  out  24  count word; rsp_timeout  out  1  poll timeout flag.
REQ-012 SHALL have bus-master ports saddress  out  16; srd  out  1; swr  out  1; sdata_in  out  32 (write data); sdata_out  in  32 (read data); names wire 1:1 to the peripheral's ports.

Function
REQ-013 SHALL implement states IDLE, WR_A1, WR_A2, WR_GO, RD_STAT, RD_W0, RD_W1, RD_L, RESP.
REQ-014 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, latch cmd_a1/cmd_a2 and go to WR_A1 next cycle.
REQ-015 SHALL perform each bus access as: 1 setup cycle (address/data valid, strobes low), STROBE_LEN strobe cycles, 1 hold cycle (strobes low, address/data stable); access length STROBE_LEN+2 cycles.
REQ-016 SHALL never assert srd and swr together, and SHALL keep saddress/sdata_in constant for the whole access.
REQ-017 SHALL sample sdata_out on the hold cycle of a read access.
REQ-018 SHALL write {8'h0,a1} to ADDR_A1 (WR_A1), {8'h0,a2} to ADDR_A2 (WR_A2), then 32'h0 to ADDR_CTRL (WR_GO), each one access, back-to-back.
REQ-019 SHALL in RD_STAT read ADDR_CTRL; done when sdata_out[1:0] != 2'b11 -> RD_W0; busy with poll count < POLL_MAX -> increment count, one idle cycle, re-read; busy with count == POLL_MAX -> RESP with rsp_timeout=1, rsp_w=0, rsp_l=0.
REQ-020 SHALL reset the poll counter (16 bits) on entry to WR_GO; counter never wraps.
REQ-021 SHALL read ADDR_W twice (RD_W0 discarded, RD_W1 kept) because the peripheral returns the previously latched word on first read.
REQ-022 SHALL read ADDR_L in RD_L and keep sdata_out[23:0] as rsp_l; bits 31:24 ignored.
REQ-023 SHALL in RESP hold rsp_valid=1 and rsp_w/rsp_l/rsp_timeout stable until rsp_ready=1, then return to IDLE next cycle with rsp_valid=0.
REQ-024 SHALL hold rsp_w/rsp_l/rsp_timeout at last value outside RESP; rsp_timeout cleared on next command acceptance.
REQ-025 SHALL ignore cmd_valid in every state except IDLE; operands change mid-sequence have no effect.
REQ-026 SHALL drive saddress=0, sdata_in=0, srd=0, swr=0 when not in a bus access.

Reset
REQ-027 SHALL, on rising clk with n_reset=0, set state IDLE, cmd_ready=0 during reset and 1 first cycle after, rsp_valid=0, rsp_w=0, rsp_l=0, rsp_timeout=0, saddress=0, srd=0, swr=0, sdata_in=0, poll counter 0.
REQ-028 SHALL on reset mid-access drop srd/swr at that same edge; no partial access resumes.

Verification
REQ-029 SHALL cover: a1=3, a2=4, peripheral model W=0x30, L=1, done after 2 polls -> bus trace A1/A2/CTRL writes, 3 status reads, 2 W reads, 1 L read; rsp_w=0x30, rsp_l=1, rsp_timeout=0.
REQ-030 SHALL cover: STROBE_LEN=1 and 4 -> every access exactly 3 and 6 cycles, strobe high 1 and 4 cycles.
REQ-031 SHALL cover: status stuck at 2'b11, POLL_MAX=4 -> exactly 5 status reads, rsp_timeout=1, rsp_w=0, rsp_l=0.
REQ-032 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and data stable 10 cycles; new cmd_valid meanwhile ignored.
REQ-033 SHALL cover: n_reset=0 during strobe of WR_A2 -> srd=swr=0 at that edge, all outputs reset, next command runs full sequence from WR_A1.
REQ-034 SHALL cover: back-to-back commands with rsp_ready=1 -> cmd_ready high one cycle after RESP, no overlap of bus accesses.
